// File: rtl/uart_rx_core.sv
// Oversampled UART receiver: 3-sample majority vote per bit, optional parity, 1 or 2 stop bits.
// Define UART_RX_BREAK_DET_EN to report all-zero frames with a low stop bit as a break.
module uart_rx_core #(
    parameter int DATA_W     = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_tick,
    input  logic              i_rx_en,
    input  logic              i_rx_serial,
    input  logic [1:0]        i_par_mode,
    input  logic              i_stop2,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_par_err,
    output logic              o_frm_err,
    output logic              o_ovr_err,
    output logic              o_break,
    output logic              o_busy
);
    localparam int MID = OVERSAMPLE / 2;
    localparam int CW  = $clog2(OVERSAMPLE);
    localparam int IW  = $clog2(DATA_W);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] CNT_S0   = CW'(MID - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(MID);
    localparam logic [CW-1:0] CNT_S2   = CW'(MID + 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_START    = 3'd1;
    localparam logic [2:0] ST_DATA     = 3'd2;
    localparam logic [2:0] ST_PARITY   = 3'd3;
    localparam logic [2:0] ST_STOP1    = 3'd4;
    localparam logic [2:0] ST_STOP2    = 3'd5;
    localparam logic [2:0] ST_BRK_WAIT = 3'd6;

    logic              sync1_q, s_q, prev_s_q;
    logic [2:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [1:0]        par_mode_q, par_mode_d;
    logic              stop2_q, stop2_d;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;
    logic [DATA_W-1:0] shr_q;
    logic [1:0]        samp_q;
    logic              par_acc_q;
    logic [DATA_W-1:0] data_q;
    logic              valid_q, pe_q, fe_q, ovr_q;
    logic              bit_now, at_dec, at_wrap, par_en, done, done_ferr;

    assign bit_now   = (samp_q[0] & samp_q[1]) | (samp_q[0] & s_q) | (samp_q[1] & s_q);
    assign at_dec    = i_tick && (cnt_q == CNT_S2);
    assign at_wrap   = i_tick && (cnt_q == CNT_LAST);
    assign par_en    = (par_mode_q == 2'b01) || (par_mode_q == 2'b10);
    assign done_ferr = ferr_q | ~bit_now;

`ifdef UART_RX_BREAK_DET_EN
    logic pbit_q, brk_q, brk_hit, brk_frame;
    assign brk_frame = (shr_q == '0) && (!par_en || !pbit_q) && !bit_now;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        par_mode_d = par_mode_q;
        stop2_d    = stop2_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        done       = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        brk_hit    = 1'b0;
`endif
        if (state_q != ST_IDLE && !i_rx_en) begin
            state_d = ST_IDLE;
        end else if (state_q == ST_IDLE) begin
            // Frame settings are captured at the start edge and frozen for the whole frame
            if (i_tick && i_rx_en && !s_q && prev_s_q) begin
                state_d    = ST_START;
                cnt_d      = '0;
                idx_d      = '0;
                par_mode_d = i_par_mode;
                stop2_d    = i_stop2;
                perr_d     = 1'b0;
                ferr_d     = 1'b0;
            end
        end else if (state_q == ST_BRK_WAIT) begin
            if (i_tick && s_q) state_d = ST_IDLE;
        end else begin
            if (i_tick) cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
            case (state_q)
                ST_START: begin
                    if (at_dec && bit_now) state_d = ST_IDLE;
                    else if (at_wrap)      state_d = ST_DATA;
                end
                ST_DATA: begin
                    if (at_wrap) begin
                        if (idx_q == IDX_LAST) state_d = par_en ? ST_PARITY : ST_STOP1;
                        else                   idx_d   = idx_q + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (at_dec)  perr_d  = par_acc_q ^ bit_now ^ (par_mode_q == 2'b10);
                    if (at_wrap) state_d = ST_STOP1;
                end
                ST_STOP1: begin
                    if (at_dec) begin
`ifdef UART_RX_BREAK_DET_EN
                        if (brk_frame) begin
                            state_d = ST_BRK_WAIT;
                            brk_hit = 1'b1;
                        end else
`endif
                        if (stop2_q) ferr_d = ~bit_now;
                        else begin
                            done    = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else if (at_wrap) begin
                        state_d = ST_STOP2;
                    end
                end
                ST_STOP2: begin
                    if (at_dec) begin
                        done    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q    <= 1'b1;
            s_q        <= 1'b1;
            prev_s_q   <= 1'b1;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            par_mode_q <= 2'b00;
            stop2_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            pe_q       <= 1'b0;
            fe_q       <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            sync1_q    <= i_rx_serial;
            s_q        <= sync1_q;
            if (i_tick) prev_s_q <= s_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            par_mode_q <= par_mode_d;
            stop2_q    <= stop2_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            ovr_q      <= 1'b0;
            // A finished frame only lands if the register is empty or being drained this cycle
            if (done) begin
                if (!valid_q || i_ready) begin
                    data_q  <= shr_q;
                    pe_q    <= par_en & perr_q;
                    fe_q    <= done_ferr;
                    valid_q <= 1'b1;
                end else begin
                    ovr_q   <= 1'b1;
                end
            end else if (valid_q && i_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    // Frame datapath: only meaningful between start edge and completion, so no reset
    always_ff @(posedge i_clk) begin
        if (i_tick && cnt_q == CNT_S0) samp_q[0] <= s_q;
        if (i_tick && cnt_q == CNT_S1) samp_q[1] <= s_q;
        if (state_q == ST_IDLE) begin
            par_acc_q <= 1'b0;
        end else if (state_q == ST_DATA && at_dec) begin
            shr_q     <= {bit_now, shr_q[DATA_W-1:1]};
            par_acc_q <= par_acc_q ^ bit_now;
        end
    end

`ifdef UART_RX_BREAK_DET_EN
    always_ff @(posedge i_clk) begin
        if (state_q == ST_PARITY && at_dec) pbit_q <= bit_now;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) brk_q <= 1'b0;
        else          brk_q <= brk_hit;
    end

    assign o_break = brk_q;
`else
    assign o_break = 1'b0;
`endif

    assign o_data    = data_q;
    assign o_valid   = valid_q;
    assign o_par_err = pe_q;
    assign o_frm_err = fe_q;
    assign o_ovr_err = ovr_q;
    assign o_busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core (8 data bits, 16x oversample, tick every 4 clocks).
module tb_uart_rx_core;
    localparam int BITC = 64;
`ifdef UART_RX_BREAK_DET_EN
    localparam bit BRK_EN = 1'b1;
`else
    localparam bit BRK_EN = 1'b0;
`endif

    logic       clk = 1'b0, rst_n = 1'b0, tick = 1'b0, rx_en = 1'b0, ser = 1'b1;
    logic       stop2 = 1'b0, ready = 1'b1;
    logic [1:0] par_mode = 2'b00;
    logic [7:0] o_data;
    logic       o_valid, o_par_err, o_frm_err, o_ovr_err, o_break, o_busy;

    uart_rx_core #(.DATA_W(8), .OVERSAMPLE(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_rx_en(rx_en),
        .i_rx_serial(ser), .i_par_mode(par_mode), .i_stop2(stop2), .i_ready(ready),
        .o_data(o_data), .o_valid(o_valid), .o_par_err(o_par_err), .o_frm_err(o_frm_err),
        .o_ovr_err(o_ovr_err), .o_break(o_break), .o_busy(o_busy)
    );

    initial forever #5 clk = ~clk;

    initial begin
        int div;
        div = 0;
        forever begin
            @(posedge clk); #1;
            tick = (div == 3);
            div  = (div + 1) % 4;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [7:0] d; logic pe; logic fe; } rec_t;
    rec_t got[$];
    int   n_ovr = 0, n_brk = 0, vrise_cyc = 0, vlen = 0, vlen_last = 0;
    bit   busy_seen = 1'b0;
    logic prev_v = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (o_valid && ready) got.push_back('{o_data, o_par_err, o_frm_err});
            if (o_valid && !prev_v) vrise_cyc = cyc;
            if (o_valid) vlen++;
            else if (prev_v) begin vlen_last = vlen; vlen = 0; end
            if (o_ovr_err) n_ovr++;
            if (o_break) n_brk++;
            if (o_busy) busy_seen = 1'b1;
        end
        prev_v = o_valid;
    end

    int total = 0, bad = 0, start_cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic expect_rec(input string name, input logic [7:0] ed, input logic epe, input logic efe);
        rec_t r;
        chk({name, "_count"}, got.size(), 1);
        if (got.size() > 0) begin
            r = got.pop_front();
            chk({name, "_data"}, r.d, ed);
            chk({name, "_pe"}, r.pe, epe);
            chk({name, "_fe"}, r.fe, efe);
        end
        got.delete();
    endtask

    task automatic hold_line(input logic b, input int nclk);
        ser = b;
        repeat (nclk) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [1:0] pm, input logic st2,
                              input logic pb, input logic sb1, input logic sb2, input int idle_bits);
        par_mode  = pm;
        stop2     = st2;
        start_cyc = cyc;
        hold_line(1'b0, BITC);
        for (int i = 0; i < 8; i++) hold_line(d[i], BITC);
        if (pm == 2'b01 || pm == 2'b10) hold_line(pb, BITC);
        hold_line(sb1, BITC);
        if (st2) hold_line(sb2, BITC);
        hold_line(1'b1, idle_bits * BITC);
    endtask

    // Expected outcome of one frame, straight from the line-protocol rules
    task automatic model(input logic [7:0] d, input logic [1:0] pm, input logic st2, input logic pb,
                         input logic sb1, input logic sb2, output bit brk, output logic pe, output logic fe);
        int ones;
        bit pen;
        ones = $countones(d);
        pen  = (pm == 2'b01) || (pm == 2'b10);
        pe   = pen && (((ones + int'(pb)) % 2) != ((pm == 2'b10) ? 1 : 0));
        fe   = !sb1 || (st2 && !sb2);
        brk  = BRK_EN && (d == 8'h00) && (!pen || !pb) && !sb1;
    endtask

    typedef struct {
        logic [7:0] d; logic [1:0] pm; logic st2; logic pb; logic sb1; logic sb2;
        logic [7:0] ed; logic epe; logic efe;
    } vec_t;
    vec_t vecs[10];

    initial begin
        logic [7:0] d;
        logic [1:0] pm;
        logic       st2, pb, sb1, sb2, epe, efe;
        bit         brk;
        int         b0;

        vecs[0] = '{8'hA5, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0};
        vecs[2] = '{8'h03, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0};
        vecs[3] = '{8'h03, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0};
        vecs[4] = '{8'h5A, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0};
        vecs[5] = '{8'hFF, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1};
        vecs[6] = '{8'h3C, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1};
        vecs[7] = '{8'h80, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};
        vecs[8] = '{8'h7E, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 8'h7E, 1'b0, 1'b0};
        vecs[9] = '{8'h7E, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1, 8'h7E, 1'b1, 1'b0};

        rx_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", o_valid, 0);
        chk("rst_data", o_data, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_flags", {o_par_err, o_frm_err, o_ovr_err, o_break}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        hold_line(1'b1, 2 * BITC);

        // Basic 8N1 frame: latency and single-cycle valid
        got.delete();
        send_frame(8'hA5, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        chk("a5_latency_window", int'((vrise_cyc - start_cyc) >= 9 * BITC && (vrise_cyc - start_cyc) <= 10 * BITC), 1);
        chk("a5_valid_len", vlen_last, 1);
        expect_rec("a5", 8'hA5, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            got.delete();
            send_frame(vecs[i].d, vecs[i].pm, vecs[i].st2, vecs[i].pb, vecs[i].sb1, vecs[i].sb2, 1);
            expect_rec($sformatf("vec%0d", i), vecs[i].ed, vecs[i].epe, vecs[i].efe);
        end

        // Short low glitch is rejected as a false start
        got.delete();
        par_mode  = 2'b00;
        stop2     = 1'b0;
        busy_seen = 1'b0;
        hold_line(1'b0, 16);
        hold_line(1'b1, 2 * BITC);
        chk("glitch_busy_seen", busy_seen, 1);
        chk("glitch_busy_end", o_busy, 0);
        chk("glitch_no_frame", got.size(), 0);
        chk("glitch_valid", o_valid, 0);

        // Long low line: break or zero frame with framing error
        got.delete();
        b0 = n_brk;
        hold_line(1'b0, 12 * BITC);
        hold_line(1'b1, 2 * BITC);
`ifdef UART_RX_BREAK_DET_EN
        chk("break_pulse", n_brk - b0, 1);
        chk("break_no_frame", got.size(), 0);
`else
        chk("break_pulse", n_brk - b0, 0);
        expect_rec("break_frame", 8'h00, 1'b0, 1'b1);
`endif
        got.delete();
        send_frame(8'h5A, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        expect_rec("rearm", 8'h5A, 1'b0, 1'b0);

        // Overrun while the consumer stalls
        got.delete();
        ready = 1'b0;
        b0    = n_ovr;
        send_frame(8'h11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        send_frame(8'h22, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        chk("ovr_valid_held", o_valid, 1);
        chk("ovr_data_held", o_data, 8'h11);
        chk("ovr_pulses", n_ovr - b0, 1);
        ready = 1'b1;
        hold_line(1'b1, 4);
        expect_rec("ovr_drain", 8'h11, 1'b0, 1'b0);
        chk("ovr_valid_clear", o_valid, 0);

        // Reset in the middle of a data bit, with a word held in the output register
        ready = 1'b0;
        send_frame(8'h77, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        chk("pre_rst_valid", o_valid, 1);
        chk("pre_rst_data", o_data, 8'h77);
        hold_line(1'b0, BITC);
        hold_line(1'b1, BITC + BITC / 2);
        chk("pre_rst_busy", o_busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", o_valid, 0);
        chk("mid_rst_data", o_data, 0);
        chk("mid_rst_busy", o_busy, 0);
        chk("mid_rst_flags", {o_par_err, o_frm_err, o_ovr_err, o_break}, 0);
        @(posedge clk); #1;
        hold_line(1'b1, 8);
        rst_n = 1'b1;
        ready = 1'b1;
        hold_line(1'b1, 2 * BITC);
        got.delete();
        send_frame(8'h5A, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        expect_rec("post_rst", 8'h5A, 1'b0, 1'b0);

        // Receiver disabled mid-frame: abort without output
        got.delete();
        hold_line(1'b0, BITC);
        hold_line(1'b0, BITC);
        rx_en = 1'b0;
        hold_line(1'b1, 3);
        chk("abort_busy", o_busy, 0);
        hold_line(1'b1, 8 * BITC);
        rx_en = 1'b1;
        hold_line(1'b1, BITC);
        chk("abort_no_frame", got.size(), 0);
        chk("abort_valid", o_valid, 0);
        send_frame(8'hC3, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        expect_rec("post_abort", 8'hC3, 1'b0, 1'b0);

        // Randomized frames against the protocol model
        for (int n = 0; n < 30; n++) begin
            d   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            pm  = 2'($urandom);
            st2 = 1'($urandom);
            pb  = 1'($urandom);
            sb1 = ($urandom_range(0, 5) != 0);
            sb2 = ($urandom_range(0, 5) != 0);
            model(d, pm, st2, pb, sb1, sb2, brk, epe, efe);
            got.delete();
            b0 = n_brk;
            send_frame(d, pm, st2, pb, sb1, sb2, 1 + int'($urandom_range(0, 1)));
            if (brk) begin
                chk($sformatf("rnd%0d_brk", n), n_brk - b0, 1);
                chk($sformatf("rnd%0d_nodel", n), got.size(), 0);
            end else begin
                chk($sformatf("rnd%0d_nobrk", n), n_brk - b0, 0);
                expect_rec($sformatf("rnd%0d", n), d, epe, efe);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bits per frame, legal 5..16.
REQ-002 SHALL have parameter OVERSAMPLE, default 16, ticks per bit, even, legal 8..32; MID = OVERSAMPLE/2.
REQ-003 i_clk  input  1  clock; all state on rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_tick  input  1  one-cycle oversample strobe, OVERSAMPLE per bit period.
REQ-006 i_rx_en  input  1  receiver enable.
REQ-007 i_rx_serial  input  1  asynchronous serial line, idle high.
REQ-008 i_par_mode  input  2  00 none, 01 even, 10 odd, 11 treated as none.
REQ-009 i_stop2  input  1  1 = two stop bits checked, 0 = one.
REQ-010 o_data  output  DATA_W  received word, LSB = first data bit.
REQ-011 o_valid  output  1  o_data and error flags valid; held until accepted.
REQ-012 i_ready  input  1  consumer accepts when o_valid && i_ready.
REQ-013 o_par_err / o_frm_err  output  1 each  error flags accompanying o_data.
REQ-014 o_ovr_err  output  1  one-cycle pulse, frame lost to full output register.
REQ-015 o_break  output  1  one-cycle pulse on break detection.
REQ-016 o_busy  output  1  high whenever FSM is not IDLE.

Function
REQ-017 i_rx_serial SHALL pass a 2-flop synchronizer (reset value 1); all logic uses synchronized value s.
REQ-018 FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, BRK_WAIT; tick counter cnt 0..OVERSAMPLE-1, bit index 0..DATA_W-1.
REQ-019 IDLE->START on i_tick && i_rx_en && s==0 with previous tick-sampled s==1 (falling edge); cnt cleared; i_par_mode, i_stop2 latched here and ignored until next frame.
REQ-020 Every bit: s sampled on ticks at cnt MID-1, MID, MID+1; bit value = majority of 3; decided at tick cnt MID+1; cnt wraps OVERSAMPLE-1 -> 0 into next bit.
REQ-021 START: majority 1 -> IDLE (false start, no output); 0 -> DATA at bit boundary.
REQ-022 DATA: DATA_W bits LSB first, then PARITY if parity enabled, else STOP1.
REQ-023 PARITY: error if XOR(data, parity bit) != 0 (even) or != 1 (odd).
REQ-024 STOP1 (and STOP2 if latched): stop bit 0 sets frm_err; frame completes at decision tick of last stop bit, FSM -> IDLE same cycle (no wait for bit end).
REQ-025 Completion: o_data, o_par_err, o_frm_err load and o_valid=1 next cycle, provided register empty or accepted that cycle.
REQ-026 Completion with o_valid=1 and i_ready=0: new frame discarded, register unchanged, o_ovr_err pulses 1 cycle.
REQ-027 Completion coinciding with accept: new frame loaded, o_valid stays 1, no overrun.
REQ-028 Accept with no completion: o_valid -> 0 next cycle; flags keep values but are don't-care.
REQ-029 i_rx_en=0 in any non-IDLE state: abort to IDLE next cycle, no output, no error; held output register unaffected.
REQ-030 i_tick absent: FSM and counters hold.

Reset
REQ-031 Reset SHALL force IDLE, cnt=0, index=0, synchronizer=1, o_data=0, o_valid=0, all error flags and o_break=0, o_busy=0, from assertion.
REQ-032 Reset mid-frame discards partial frame; first frame after release requires a fresh falling edge.

Configuration
REQ-033 Macro UART_RX_BREAK_DET_EN defined: frame with all data 0, parity bit 0 (if enabled) and STOP1 0 -> o_break pulse, frame not delivered, FSM -> BRK_WAIT until tick-sampled s==1, then IDLE.
REQ-034 Macro undefined: such frame delivered as o_data=0 with o_frm_err=1; BRK_WAIT unreachable; o_break tied 0.

Verification
REQ-035 8N1, OVERSAMPLE=16, send 0xA5, i_ready=1 -> o_data=0xA5, o_valid 1 cycle, no flags, ~9.5 bit periods after start edge.
REQ-036 8E1 send 0x03 with parity bit 1 -> o_data=0x03, o_par_err=1; i_par_mode=10 same frame -> o_par_err=0.
REQ-037 Low glitch of 4 ticks on idle line -> START->IDLE, o_busy pulse, o_valid stays 0.
REQ-038 i_ready=0, send 0x11 then 0x22 -> o_data=0x11 held, o_ovr_err pulse at 0x22 completion; i_stop2=1 with second stop 0 -> o_frm_err=1.
REQ-039 Line low 12 bit periods, 8N1 -> with macro: one o_break, no o_valid, re-arm after line high; without: o_data=0x00, o_frm_err=1.
REQ-040 Assert i_rst_n mid-DATA, release, send 0x5A -> all outputs 0 during reset, then o_data=0x5A clean.
